// File: rtl/sm_stream_accumulator_if.sv
// sm_stream_accumulator_if: sample-in / frame-out handshake bundle for sm_stream_accumulator
interface sm_stream_accumulator_if #(
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_WIDTH-1:0]  out_data;
   logic                  out_sat;
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/sm_stream_accumulator.sv
// sm_stream_accumulator: sums COUNT sign-magnitude samples into a saturating two's-complement frame result
module sm_stream_accumulator #(
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = 8,
   parameter int COUNT      = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   sm_stream_accumulator_if.slave s
);
   localparam int CW = $clog2(COUNT + 1);
   typedef enum logic {ACCUM, HOLD} state_t;
   state_t               state, state_next;
   logic [ACC_WIDTH-1:0] acc, sat_sum;
   logic [CW-1:0]        cnt;
   logic                 sticky, in_fire, out_fire, last, clamp;
   logic [ACC_WIDTH:0]   mag, sample, sum;
   assign mag      = (ACC_WIDTH + 1)'(s.in_data[DATA_WIDTH-2:0]);
   assign sample   = s.in_data[DATA_WIDTH-1] ? -mag : mag;
   // one guard bit: overflow shows up as the top two bits disagreeing
   assign sum      = {acc[ACC_WIDTH-1], acc} + sample;
   assign clamp    = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
   assign sat_sum  = clamp ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
   assign in_fire  = s.in_valid && s.in_ready;
   assign out_fire = s.out_valid && s.out_ready;
   assign last     = cnt == CW'(COUNT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ACCUM;
      else state <= state_next;
   always_comb
      state_next = (in_fire && last) ? HOLD : out_fire ? ACCUM : state;
   always_comb begin
      s.in_ready  = state == ACCUM;
      s.out_valid = state == HOLD;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
      end else if (out_fire) begin
         acc    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
      end else if (in_fire) begin
         acc    <= sat_sum;
         cnt    <= cnt + 1'b1;
         sticky <= sticky | clamp;
      end
   assign s.out_data = acc;
   assign s.out_sat  = sticky;
endmodule

// File: tb/tb_sm_stream_accumulator.sv
// tb_sm_stream_accumulator: directed checks on default, 5-bit-accumulator and single-sample-frame instances
module tb_sm_stream_accumulator;
   logic clk, rst_n;
   int   checks = 0;
   int   errors = 0;
   sm_stream_accumulator_if #(.DATA_WIDTH(4), .ACC_WIDTH(8)) ia ();
   sm_stream_accumulator_if #(.DATA_WIDTH(4), .ACC_WIDTH(5)) ib ();
   sm_stream_accumulator_if #(.DATA_WIDTH(4), .ACC_WIDTH(8)) ic ();
   sm_stream_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .COUNT(4)) dut_a (.clk(clk), .rst_n(rst_n), .s(ia));
   sm_stream_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(5), .COUNT(4)) dut_b (.clk(clk), .rst_n(rst_n), .s(ib));
   sm_stream_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .COUNT(1)) dut_c (.clk(clk), .rst_n(rst_n), .s(ic));
   // observed = {in_ready, out_valid, out_sat, out_data}
   logic [10:0] obs_a, obs_c;
   logic [7:0]  obs_b;
   assign obs_a = {ia.in_ready, ia.out_valid, ia.out_sat, ia.out_data};
   assign obs_b = {ib.in_ready, ib.out_valid, ib.out_sat, ib.out_data};
   assign obs_c = {ic.in_ready, ic.out_valid, ic.out_sat, ic.out_data};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic push_a(input logic [3:0] d);
      ia.in_valid = 1'b1;
      ia.in_data  = d;
      @(posedge clk); #1;
      ia.in_valid = 1'b0;
   endtask
   task automatic push_b(input logic [3:0] d);
      ib.in_valid = 1'b1;
      ib.in_data  = d;
      @(posedge clk); #1;
      ib.in_valid = 1'b0;
   endtask
   task automatic push_c(input logic [3:0] d);
      ic.in_valid = 1'b1;
      ic.in_data  = d;
      @(posedge clk); #1;
      ic.in_valid = 1'b0;
   endtask
   task automatic release_a();
      ia.out_ready = 1'b1;
      @(posedge clk); #1;
      ia.out_ready = 1'b0;
   endtask
   task automatic release_b();
      ib.out_ready = 1'b1;
      @(posedge clk); #1;
      ib.out_ready = 1'b0;
   endtask
   task automatic release_c();
      ic.out_ready = 1'b1;
      @(posedge clk); #1;
      ic.out_ready = 1'b0;
   endtask
   task automatic test_reset();
      #2;
      checks++; if (obs_a !== {3'b100, 8'h00}) begin errors++; $display("FAIL reset_a got %h want %h", obs_a, {3'b100, 8'h00}); end
      checks++; if (obs_b !== {3'b100, 5'h00}) begin errors++; $display("FAIL reset_b got %h want %h", obs_b, {3'b100, 5'h00}); end
      #6 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (obs_c !== {3'b100, 8'h00}) begin errors++; $display("FAIL reset_c got %h want %h", obs_c, {3'b100, 8'h00}); end
   endtask
   task automatic test_basic();
      push_a(4'h3);
      push_a(4'hA);
      push_a(4'h7);
      checks++; if (obs_a[10:9] !== 2'b10) begin errors++; $display("FAIL basic_partial got %b want %b", obs_a[10:9], 2'b10); end
      push_a(4'h9);
      checks++; if (obs_a !== {3'b010, 8'h07}) begin errors++; $display("FAIL basic_frame got %h want %h", obs_a, {3'b010, 8'h07}); end
      release_a();
      checks++; if (obs_a[10:9] !== 2'b10) begin errors++; $display("FAIL basic_release got %b want %b", obs_a[10:9], 2'b10); end
   endtask
   task automatic test_neg_zero();
      for (int i = 0; i < 4; i++) push_a(4'h8);
      checks++; if (obs_a !== {3'b010, 8'h00}) begin errors++; $display("FAIL neg_zero got %h want %h", obs_a, {3'b010, 8'h00}); end
      release_a();
   endtask
   task automatic test_backpressure();
      push_a(4'h1);
      ia.in_data = 4'h7;
      @(posedge clk); #1;
      push_a(4'h2);
      push_a(4'h3);
      push_a(4'h4);
      ia.in_valid = 1'b1;
      ia.in_data  = 4'h7;
      for (int i = 0; i < 3; i++) begin
         checks++; if (obs_a !== {3'b010, 8'h0A}) begin errors++; $display("FAIL hold_%0d got %h want %h", i, obs_a, {3'b010, 8'h0A}); end
         @(posedge clk); #1;
      end
      release_a();
      checks++; if (obs_a[10:9] !== 2'b10) begin errors++; $display("FAIL bp_release got %b want %b", obs_a[10:9], 2'b10); end
      ia.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) push_a(4'h1);
      checks++; if (obs_a !== {3'b010, 8'h04}) begin errors++; $display("FAIL bp_next_frame got %h want %h", obs_a, {3'b010, 8'h04}); end
      release_a();
   endtask
   task automatic test_saturation();
      for (int i = 0; i < 4; i++) push_b(4'h7);
      checks++; if (obs_b !== {3'b011, 5'h0F}) begin errors++; $display("FAIL sat_pos got %h want %h", obs_b, {3'b011, 5'h0F}); end
      release_b();
      for (int i = 0; i < 4; i++) push_b(4'hF);
      checks++; if (obs_b !== {3'b011, 5'h10}) begin errors++; $display("FAIL sat_neg got %h want %h", obs_b, {3'b011, 5'h10}); end
      release_b();
      push_b(4'h7);
      push_b(4'h7);
      push_b(4'h7);
      push_b(4'hF);
      checks++; if (obs_b !== {3'b011, 5'h08}) begin errors++; $display("FAIL sat_sticky got %h want %h", obs_b, {3'b011, 5'h08}); end
      release_b();
      for (int i = 0; i < 4; i++) push_b(4'h1);
      checks++; if (obs_b !== {3'b010, 5'h04}) begin errors++; $display("FAIL sat_cleared got %h want %h", obs_b, {3'b010, 5'h04}); end
      release_b();
   endtask
   task automatic test_count_one();
      push_c(4'hD);
      checks++; if (obs_c !== {3'b010, 8'hFB}) begin errors++; $display("FAIL c1_neg got %h want %h", obs_c, {3'b010, 8'hFB}); end
      release_c();
      checks++; if (obs_c[10:9] !== 2'b10) begin errors++; $display("FAIL c1_release got %b want %b", obs_c[10:9], 2'b10); end
      push_c(4'h6);
      checks++; if (obs_c !== {3'b010, 8'h06}) begin errors++; $display("FAIL c1_pos got %h want %h", obs_c, {3'b010, 8'h06}); end
      release_c();
      push_c(4'h8);
      checks++; if (obs_c !== {3'b010, 8'h00}) begin errors++; $display("FAIL c1_neg_zero got %h want %h", obs_c, {3'b010, 8'h00}); end
      release_c();
   endtask
   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) push_a(4'h1);
      checks++; if (obs_a !== {3'b010, 8'h04}) begin errors++; $display("FAIL rst_pre_hold got %h want %h", obs_a, {3'b010, 8'h04}); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (obs_a !== {3'b100, 8'h00}) begin errors++; $display("FAIL rst_in_hold got %h want %h", obs_a, {3'b100, 8'h00}); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      push_a(4'h3);
      push_a(4'h2);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (obs_a !== {3'b100, 8'h00}) begin errors++; $display("FAIL rst_mid_frame got %h want %h", obs_a, {3'b100, 8'h00}); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) push_a(4'h1);
      checks++; if (obs_a !== {3'b010, 8'h04}) begin errors++; $display("FAIL rst_fresh_frame got %h want %h", obs_a, {3'b010, 8'h04}); end
      release_a();
   endtask
   initial begin
      rst_n = 1'b0;
      ia.in_valid = 1'b0; ia.in_data = '0; ia.out_ready = 1'b0;
      ib.in_valid = 1'b0; ib.in_data = '0; ib.out_ready = 1'b0;
      ic.in_valid = 1'b0; ic.in_data = '0; ic.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_neg_zero();
      test_backpressure();
      test_saturation();
      test_count_one();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
